// File: rtl/ldfeed16.sv
// Write-data buffer feeding a 16-bit load-enabled holding register: bursty writes in, one word per cycle out.
// Define LDFEED16_OVF_STICKY_EN to make ovf a sticky flag; otherwise it pulses once per dropped write.
module ldfeed16 #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          sys_clk,
   input  logic          reset,
   input  logic [0:15]   din,
   input  logic          wr,
   input  logic          hold,
   output logic [0:15]   dout,
   output logic          ld,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          ovf
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [0:15]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          wr_accept;
   logic          wr_drop;
   logic [AW:0]   count_next;

   // A pop frees a slot in the same edge, so a full FIFO still accepts a write while draining.
   assign pop       = !empty && !hold;
   assign wr_accept = wr && (!full || pop);
   assign wr_drop   = wr && full && !pop;

   always_comb begin
      // NOTE: default first so every path assigns count_next and no latch is inferred.
      count_next = count;
      if (wr_accept && !pop)
         count_next = count + 1'b1;
      else if (pop && !wr_accept)
         count_next = count - 1'b1;
   end

   // NOTE: storage has no reset; stale entries are never emitted because count gates every pop.
   always_ff @(posedge sys_clk) begin
      if (wr_accept)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
         ld     <= 1'b0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         ovf    <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every term above sees pre-edge state.
         if (wr_accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            dout   <= mem[rd_ptr];
         end
         ld    <= pop;
         count <= count_next;
         full  <= (count_next == DEPTH_C);
         empty <= (count_next == '0);
`ifdef LDFEED16_OVF_STICKY_EN
         if (wr_drop)
            ovf <= 1'b1;
`else
         ovf <= wr_drop;
`endif
      end
   end

endmodule

// File: tb/tb_ldfeed16.sv
// Directed bench for ldfeed16: reset, latency, overflow, streaming, hold and mid-burst reset.
// Honours LDFEED16_OVF_STICKY_EN when computing expected ovf.
module tb_ldfeed16;

`ifdef LDFEED16_OVF_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b1;
   logic [0:15] din     = '0;
   logic        wr      = 1'b0;
   logic        hold    = 1'b0;
   logic [0:15] dout;
   logic        ld;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        ovf;

   int passed = 0;
   int total  = 0;

   ldfeed16 #(.DEPTH(4), .AW(2)) dut (
      .sys_clk(sys_clk), .reset(reset), .din(din), .wr(wr), .hold(hold),
      .dout(dout), .ld(ld), .full(full), .empty(empty), .count(count), .ovf(ovf)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one edge; outputs are then sampled 1ns after it.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      wr = 1'b0; hold = 1'b0; din = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      total++;
      if ({dout, ld, empty, full, count, ovf} !== {16'h0000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0})
         $display("FAIL reset_values: got dout=%h ld=%b empty=%b full=%b count=%0d ovf=%b, want 0000 0 1 0 0 0",
                  dout, ld, empty, full, count, ovf);
      else passed++;
      reset = 1'b0;
      tick(); tick();
      total++;
      if ({dout, ld, empty, count, ovf} !== {16'h0000, 1'b0, 1'b1, 3'd0, 1'b0})
         $display("FAIL idle_after_reset: got dout=%h ld=%b empty=%b count=%0d ovf=%b", dout, ld, empty, count, ovf);
      else passed++;
   endtask

   task automatic test_single_write();
      do_reset();
      din = 16'h1234; wr = 1'b1;
      tick();
      wr = 1'b0;
      total++;
      if ({ld, count, empty} !== {1'b0, 3'd1, 1'b0})
         $display("FAIL single_stored: got ld=%b count=%0d empty=%b, want 0 1 0", ld, count, empty);
      else passed++;
      tick();
      total++;
      if ({ld, dout, count, empty} !== {1'b1, 16'h1234, 3'd0, 1'b1})
         $display("FAIL single_pop: got ld=%b dout=%h count=%0d empty=%b, want 1 1234 0 1", ld, dout, count, empty);
      else passed++;
      tick();
      total++;
      if ({ld, dout} !== {1'b0, 16'h1234})
         $display("FAIL single_after: got ld=%b dout=%h, want 0 1234", ld, dout);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [0:15] exp_d;
      do_reset();
      hold = 1'b1; wr = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 16'(i);
         tick();
      end
      total++;
      if ({count, full, ovf} !== {3'd4, 1'b1, 1'b0})
         $display("FAIL ovf_fill: got count=%0d full=%b ovf=%b, want 4 1 0", count, full, ovf);
      else passed++;
      din = 16'h0005;
      tick();
      total++;
      if ({count, full, ovf} !== {3'd4, 1'b1, 1'b1})
         $display("FAIL ovf_drop: got count=%0d full=%b ovf=%b, want 4 1 1", count, full, ovf);
      else passed++;
      wr = 1'b0; hold = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_d = 16'(i);
         total++;
         if ({ld, dout, count, ovf} !== {1'b1, exp_d, 3'(4 - i), STICKY})
            $display("FAIL ovf_drain%0d: got ld=%b dout=%h count=%0d ovf=%b, want 1 %h %0d %b",
                     i, ld, dout, count, ovf, exp_d, 4 - i, STICKY);
         else passed++;
      end
      tick();
      total++;
      if ({ld, empty, ovf} !== {1'b0, 1'b1, STICKY})
         $display("FAIL ovf_end: got ld=%b empty=%b ovf=%b, want 0 1 %b", ld, empty, ovf, STICKY);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [0:15] exp_d;
      do_reset();
      hold = 1'b1; wr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 16'hA000 + 16'(i);
         tick();
      end
      hold = 1'b0;
      for (int i = 4; i < 10; i++) begin
         din = 16'hA000 + 16'(i);
         tick();
         exp_d = 16'hA000 + 16'(i - 4);
         total++;
         if ({ld, dout, count, full, ovf} !== {1'b1, exp_d, 3'd4, 1'b1, 1'b0})
            $display("FAIL stream%0d: got ld=%b dout=%h count=%0d full=%b ovf=%b, want 1 %h 4 1 0",
                     i, ld, dout, count, full, ovf, exp_d);
         else passed++;
      end
      wr = 1'b0;
      for (int i = 6; i < 10; i++) begin
         tick();
         exp_d = 16'hA000 + 16'(i);
         total++;
         if ({ld, dout, count} !== {1'b1, exp_d, 3'(9 - i)})
            $display("FAIL stream_drain%0d: got ld=%b dout=%h count=%0d, want 1 %h %0d",
                     i, ld, dout, count, exp_d, 9 - i);
         else passed++;
      end
      tick();
      total++;
      if ({ld, empty} !== {1'b0, 1'b1})
         $display("FAIL stream_end: got ld=%b empty=%b, want 0 1", ld, empty);
      else passed++;
   endtask

   task automatic test_hold();
      do_reset();
      hold = 1'b1; wr = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 16'hC000 + 16'(i);
         tick();
      end
      wr = 1'b0; hold = 1'b0;
      tick();
      total++;
      if ({ld, dout, count} !== {1'b1, 16'hC001, 3'd3})
         $display("FAIL hold_pop1: got ld=%b dout=%h count=%0d, want 1 c001 3", ld, dout, count);
      else passed++;
      tick();
      hold = 1'b1;
      #1;
      total++;
      if ({ld, dout, count} !== {1'b1, 16'hC002, 3'd2})
         $display("FAIL hold_ld_kept: got ld=%b dout=%h count=%0d, want 1 c002 2", ld, dout, count);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if ({ld, dout, count} !== {1'b0, 16'hC002, 3'd2})
            $display("FAIL hold_paused%0d: got ld=%b dout=%h count=%0d, want 0 c002 2", i, ld, dout, count);
         else passed++;
      end
      hold = 1'b0;
      tick();
      total++;
      if ({ld, dout, count} !== {1'b1, 16'hC003, 3'd1})
         $display("FAIL hold_resume3: got ld=%b dout=%h count=%0d, want 1 c003 1", ld, dout, count);
      else passed++;
      tick();
      total++;
      if ({ld, dout, count, empty} !== {1'b1, 16'hC004, 3'd0, 1'b1})
         $display("FAIL hold_resume4: got ld=%b dout=%h count=%0d empty=%b, want 1 c004 0 1", ld, dout, count, empty);
      else passed++;
      tick();
      total++;
      if (ld !== 1'b0)
         $display("FAIL hold_end: got ld=%b, want 0", ld);
      else passed++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      hold = 1'b1; wr = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         din = 16'hE000 + 16'(i);
         tick();
      end
      wr = 1'b0; hold = 1'b0;
      tick();
      total++;
      if ({ld, dout, count} !== {1'b1, 16'hE001, 3'd3})
         $display("FAIL midrst_pre: got ld=%b dout=%h count=%0d, want 1 e001 3", ld, dout, count);
      else passed++;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({ld, dout, count, empty, full} !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b0})
         $display("FAIL midrst_async: got ld=%b dout=%h count=%0d empty=%b full=%b, want 0 0000 0 1 0",
                  ld, dout, count, empty, full);
      else passed++;
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({ld, empty, count} !== {1'b0, 1'b1, 3'd0})
            $display("FAIL midrst_idle%0d: got ld=%b empty=%b count=%0d, want 0 1 0", i, ld, empty, count);
         else passed++;
      end
      din = 16'h5555; wr = 1'b1;
      tick();
      wr = 1'b0;
      total++;
      if ({ld, count} !== {1'b0, 3'd1})
         $display("FAIL midrst_write: got ld=%b count=%0d, want 0 1", ld, count);
      else passed++;
      tick();
      total++;
      if ({ld, dout} !== {1'b1, 16'h5555})
         $display("FAIL midrst_first_ld: got ld=%b dout=%h, want 1 5555", ld, dout);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_overflow();
      test_back_to_back();
      test_hold();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ldfeed16.md
Name: ldfeed16

Overview:
- 16-bit write-data buffer sitting directly upstream of the 16-bit load-enabled holding register (fdsync16-class).
- Accepts bursty word writes from the bus side and stores them in a small FIFO.
- Drains one word per cycle into the holding register, driving its d and ld inputs.
- Drain pauses while the consumer asserts hold.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- sys_clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  [0:15]  write data; bit 0 is MSB, matching the downstream register bit order.
- wr  in  1  write strobe; one word per cycle while high.
- hold  in  1  downstream not ready; blocks pops while high.
- dout  out  [0:15]  word presented to downstream d; registered.
- ld  out  1  one-cycle load strobe to downstream ld; registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  current occupancy, 0..DEPTH.
- ovf  out  1  overflow indication; see Optional Feature.

Behaviour:
- Reset values (async assert, immediate):
  - dout=0, ld=0, count=0, empty=1, full=0, ovf=0.
  - Read and write pointers=0.
  - FIFO contents don't-care and never emitted.
- pop condition, evaluated on current-cycle state: !empty && !hold.
- Pop at edge E:
  - dout <= head entry; read pointer increments.
  - ld=1 for the cycle after E.
  - If no pop at E, ld <= 0 and dout holds its last value.
- Back-to-back pops allowed: ld stays high on consecutive cycles with a new dout each cycle.
- Write acceptance: wr && (!full || pop) — the word at write pointer is stored and the pointer increments.
- Write while full and no pop:
  - Word is dropped; pointers and contents unchanged.
  - ovf event raised.
- count update: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- Pointers wrap modulo DEPTH. There is no separate wrap bit; count disambiguates full from empty.
- Latency: wr at edge N into an empty FIFO with hold=0 → pop at edge N+1 → ld high in cycle N+1..N+2 → downstream captures at edge N+2.
- A write to an empty FIFO is never bypassed. It is always stored first, giving a minimum of 2 edges from wr to ld.
- hold is sampled at the edge only:
  - hold rising while ld is already high does not cancel that ld; the word was already popped.
  - Once hold is seen, no further pops occur.
- Word ordering is strict FIFO; no word is ever duplicated or reordered.
- full, empty and count are registered state (derived from the count register), so they are glitch-free.
- Reset mid-burst: contents are lost; ld drops asynchronously; the first post-reset ld requires a new write.

Optional Feature:
- Macro: LDFEED16_OVF_STICKY_EN.
- Defined:
  - ovf is a sticky flag, set at the edge of a dropped write.
  - Cleared only by reset.
- Undefined:
  - ovf is a one-cycle registered pulse in the cycle after each dropped write.
  - Otherwise 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset released, no stimulus → dout=0000h, ld=0, empty=1, full=0, count=0, ovf=0.
- Single write din=1234h with hold=0 at edge N:
  - ld=1 only in cycle after N+1, with dout=1234h.
  - count returns to 0 after N+1.
- hold=1, write 0001h, 0002h, 0003h, 0004h, 0005h on 5 consecutive edges:
  - count=4, full=1; the 0005h write is dropped.
  - Non-sticky build: ovf pulses once. Sticky build: ovf stays 1.
  - Then drop hold → ld high for 4 consecutive cycles with dout 0001h, 0002h, 0003h, 0004h.
- Full FIFO, hold=0, continuous wr of A000h+i:
  - count stays 4, no drop, ovf=0.
  - dout sequence is strictly in write order.
- Assert hold during a 4-word drain after 2 ld cycles:
  - Exactly 2 (or 3 if hold arrives while ld is already high) words are emitted, and the rest are retained.
  - Releasing hold resumes from the next word with no loss or duplicate.
- Assert reset while count=3 and ld=1:
  - ld drops to 0 immediately; dout=0000h, count=0.
  - No ld occurs after release until a new write.
